// File: rtl/port_sfr_ctrl.sv
// ---------------------------------------------------------------------------
// port_sfr_ctrl
// SFR-side controller for one 8-bit EMC08 I/O port. It holds the port SFRs
// (PX, PXEN, PXIE, PXIF, PXEDG) and feeds the output latch and direction to
// the pad mux. It also synchronises and debounces the pin readback, detects
// the selected edge per pin, and raises a level interrupt to the CPU.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   sfr_addr_i          SFR address
//   sfr_wr_i/sfr_rd_i   single-cycle write / read strobes
//   sfr_wdata_i         write data
//   sfr_rdata_o         registered read data, held between reads
//   sfr_ack_o           one-cycle pulse after an access to one of our addresses
//   ports_sfr_PX_i      raw (asynchronous) pin readback from the pad mux
//   ports_sfr_PX_o      output latch to the pad mux
//   ports_sfr_PXEN_o    direction to the pad mux (1 = output)
//   irq_o               port interrupt, |(PXIF & PXIE), registered
// ---------------------------------------------------------------------------
module port_sfr_ctrl #(
  parameter logic [7:0]  ADDR_PX    = 8'h80,
  parameter logic [7:0]  ADDR_PXEN  = 8'h81,
  parameter logic [7:0]  ADDR_PXIE  = 8'h82,
  parameter logic [7:0]  ADDR_PXIF  = 8'h83,
  parameter logic [7:0]  ADDR_PXEDG = 8'h84,
  parameter int unsigned DEB_CNT    = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] sfr_addr_i,
  input  logic       sfr_wr_i,
  input  logic       sfr_rd_i,
  input  logic [7:0] sfr_wdata_i,
  output logic [7:0] sfr_rdata_o,
  output logic       sfr_ack_o,
  input  logic [7:0] ports_sfr_PX_i,
  output logic [7:0] ports_sfr_PX_o,
  output logic [7:0] ports_sfr_PXEN_o,
  output logic       irq_o
);

  // The counter toggles filt on the cycle it would have reached DEB_CNT, so
  // the last counted value is DEB_CNT-1. DEB_CNT = 0 bypasses the counter.
  localparam logic [3:0] DEB_LAST = (DEB_CNT == 0) ? 4'd0 : 4'(DEB_CNT - 1);

  logic [7:0] px, pxen, pxie, pxif, pxedg;
  logic [7:0] sync1, sync2, filt, filt_d;
  logic [3:0] cnt [8];

  logic       hit, wr_en, rd_en;
  logic [7:0] rd_data, edge_hit, pxif_next;

  // Decode, read mux and flag update
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    hit       = (sfr_addr_i == ADDR_PX)   || (sfr_addr_i == ADDR_PXEN) ||
                (sfr_addr_i == ADDR_PXIE) || (sfr_addr_i == ADDR_PXIF) ||
                (sfr_addr_i == ADDR_PXEDG);
    wr_en     = sfr_wr_i & hit;
    // A read that collides with a write is dropped; the write wins.
    rd_en     = sfr_rd_i & hit & ~sfr_wr_i;

    rd_data   = 8'h00;
    if      (sfr_addr_i == ADDR_PX)    rd_data = filt;  // pins, not the latch
    else if (sfr_addr_i == ADDR_PXEN)  rd_data = pxen;
    else if (sfr_addr_i == ADDR_PXIE)  rd_data = pxie;
    else if (sfr_addr_i == ADDR_PXIF)  rd_data = pxif;
    else if (sfr_addr_i == ADDR_PXEDG) rd_data = pxedg;

    // PXEDG bit = 0 selects rising, 1 selects falling.
    edge_hit  = (filt & ~filt_d & ~pxedg) | (~filt & filt_d & pxedg);

    pxif_next = pxif;
    if (wr_en && (sfr_addr_i == ADDR_PXIF)) pxif_next = pxif & ~sfr_wdata_i;
    // OR-ing the new edges in last lets a set beat a same-cycle clear.
    pxif_next = pxif_next | edge_hit;
  end

  // SFR registers, bus response and interrupt
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      px          <= 8'hFF;
      pxen        <= 8'h00;
      pxie        <= 8'h00;
      pxif        <= 8'h00;
      pxedg       <= 8'h00;
      sfr_rdata_o <= 8'h00;
      sfr_ack_o   <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (wr_en) begin
        if (sfr_addr_i == ADDR_PX)    px    <= sfr_wdata_i;
        if (sfr_addr_i == ADDR_PXEN)  pxen  <= sfr_wdata_i;
        if (sfr_addr_i == ADDR_PXIE)  pxie  <= sfr_wdata_i;
        if (sfr_addr_i == ADDR_PXEDG) pxedg <= sfr_wdata_i;
      end
      pxif <= pxif_next;
      if (rd_en) sfr_rdata_o <= rd_data;
      sfr_ack_o <= wr_en | rd_en;
      irq_o     <= |(pxif & pxie);
    end
  end

  // Input path: two-flop synchroniser, per-bit debounce, edge history
  // NOTE: the debounce counters are reset explicitly, element by element, so
  // a reset in the middle of a count cannot leave a stale value behind.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1  <= 8'h00;
      sync2  <= 8'h00;
      filt   <= 8'h00;
      filt_d <= 8'h00;
      for (int i = 0; i < 8; i++) cnt[i] <= 4'd0;
    end else begin
      sync1  <= ports_sfr_PX_i;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= 4'd0;
        end else if ((DEB_CNT == 0) || (cnt[i] == DEB_LAST)) begin
          filt[i] <= ~filt[i];
          cnt[i]  <= 4'd0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  assign ports_sfr_PX_o   = px;
  assign ports_sfr_PXEN_o = pxen;

endmodule

// File: doc/port_sfr_ctrl.md
Name: port_sfr_ctrl

Overview:
- SFR-side controller for one 8-bit EMC08 I/O port.
- Holds the port's SFRs: output latch PX, direction PXEN, interrupt enable PXIE, interrupt flag PXIF, edge select PXEDG.
- Drives the combinational pad-mux block with the PX and PXEN values.
- Synchronises and debounces the pin readback, detects selected edges per pin, and raises a port interrupt to the CPU.
- Instantiated once per port (P0..P3), between the CPU SFR bus and the pad mux.

Parameters:
- ADDR_PX, 8'h80, SFR address of PX: write sets the output latch, read returns the filtered pins.
- ADDR_PXEN, 8'h81, SFR address of PXEN (1 = output).
- ADDR_PXIE, 8'h82, SFR address of PXIE.
- ADDR_PXIF, 8'h83, SFR address of PXIF (write-1-to-clear).
- ADDR_PXEDG, 8'h84, SFR address of PXEDG (0 = rising, 1 = falling).
- DEB_CNT, 4, debounce length in cycles, legal range 0..15; 0 = bypass.

Ports:
- clk_i, in, 1, system clock; all state updates on the rising edge.
- rst_n_i, in, 1, asynchronous active-low reset.
- sfr_addr_i, in, 8, SFR address.
- sfr_wr_i, in, 1, write strobe, single cycle.
- sfr_rd_i, in, 1, read strobe, single cycle.
- sfr_wdata_i, in, 8, write data.
- sfr_rdata_o, out, 8, read data, registered.
- sfr_ack_o, out, 1, one-cycle pulse completing an access to one of this block's addresses.
- ports_sfr_PX_i, in, 8, raw pin readback from the pad mux (asynchronous).
- ports_sfr_PX_o, out, 8, output latch to the pad mux.
- ports_sfr_PXEN_o, out, 8, direction to the pad mux.
- irq_o, out, 1, port interrupt, level, registered.

Behaviour:
- Reset (async assert, sync release):
  - PX = 8'hFF; PXEN, PXIE, PXIF, PXEDG = 0.
  - sync1, sync2, filt = 0; all debounce counters = 0.
  - sfr_rdata_o = 0, sfr_ack_o = 0, irq_o = 0.
  - Reset mid-debounce discards the count.
- Address decode:
  - A hit is sfr_addr_i equal to one of the five ADDR_* values.
  - A non-hit strobe produces no register change, no ack, and sfr_rdata_o holds its value.
- Write (sfr_wr_i & hit):
  - The register updates at the same edge; ack pulses in the next cycle.
  - PXIF write: bits with wdata = 1 clear, bits with wdata = 0 are unchanged.
- Read (sfr_rd_i & hit):
  - sfr_rdata_o is loaded at that edge (valid the following cycle); sfr_ack_o is high in that same following cycle.
  - Reading PX returns filt, not the latch.
  - Other addresses return the register value.
- sfr_rd_i and sfr_wr_i together: the write executes, the read is discarded, ack pulses once, sfr_rdata_o is unchanged.
- Input path:
  - Two-flop synchroniser: ports_sfr_PX_i -> sync1 -> sync2.
  - Per-bit debounce counter (4 bits): increments each cycle while sync2 != filt; resets to 0 when sync2 == filt.
  - When the counter reaches DEB_CNT, filt toggles and the counter resets.
  - Pulses seen at sync2 shorter than DEB_CNT cycles are rejected.
  - DEB_CNT = 0: filt follows sync2 with one register stage.
- Latency, pin change between edges 0 and 1:
  - filt updates at edge 2+DEB_CNT (DEB_CNT = 0: edge 3).
  - PXIF sets one edge after filt.
  - irq_o asserts one edge after PXIF.
- Edge detect:
  - Per bit, compare filt with its value one cycle earlier (filt_d).
  - Rising: filt & ~filt_d. Falling: ~filt & filt_d.
  - PXEDG selects the edge type per bit.
  - A selected edge sets PXIF[i] regardless of PXEN and PXIE.
  - Set and W1C on the same bit in the same cycle: set wins.
- irq_o <= |(PXIF & PXIE), registered. Clearing the flag or the enable deasserts it one edge later.
- ports_sfr_PX_o and ports_sfr_PXEN_o are direct register outputs: no glitches, update at the write edge.

Test Plan:
- Reset, then read each address -> PX read returns filt = 8'h00 (pins low); PXEN/PXIE/PXIF/PXEDG read 0; ports_sfr_PX_o = 8'hFF; ack one cycle after each rd.
- Write PXEN = 8'h0F, PX = 8'hA5 -> ports_sfr_PXEN_o = 8'h0F and ports_sfr_PX_o = 8'hA5 after the write edge; acks pulse; read-back of PXEN = 8'h0F.
- DEB_CNT = 4, PXIE = 8'h01, PXEDG = 0; pin0 0->1 before edge 1 -> filt[0] = 1 at edge 6, PXIF = 8'h01 at edge 7, irq_o = 1 at edge 8. Write PXIF = 8'h01 -> irq_o = 0 one edge after the clear.
- Pin3 high for 3 cycles, DEB_CNT = 4 -> filt, PXIF and irq_o unchanged. Then hold 6 cycles -> PXIF[3] set (with PXEDG[3] = 0).
- PXEDG = 8'h80, pin7 1->0 with a W1C of bit 7 in the same cycle as the edge -> PXIF[7] remains 1 (set wins).
- rd and wr to ADDR_PXIE in the same cycle with wdata 8'h3C -> PXIE = 8'h3C, one ack, sfr_rdata_o unchanged. Assert rst_n_i mid-debounce -> all outputs return to reset values immediately.
